// File: rtl/vga_driver_if.sv
// Renderer-facing bus of the VGA driver: beam position out, colour for that position back in.
interface vga_driver_if;
  logic [9:0] x;
  logic [9:0] y;
  logic [3:0] red;
  logic [3:0] green;
  logic [3:0] blue;

  modport master (output x, y, input red, green, blue);
  modport slave  (input x, y, output red, green, blue);
endinterface

// File: rtl/vga_driver.sv
// VGA timing generator and registered pixel output stage (640x480@60Hz by default).
// The beam counters are published directly; sync, colour and frame strobe follow one dclk later.
module vga_driver #(
  parameter int H_VISIBLE = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33
) (
  input  logic         dclk,
  input  logic         clr,
  output logic         hsync,
  output logic         vsync,
  output logic [3:0]   red_o,
  output logic [3:0]   green_o,
  output logic [3:0]   blue_o,
  output logic         clk,
  output logic         frame_clk,
  vga_driver_if.master rif
);
  localparam logic [9:0] H_VIS_END  = 10'(H_VISIBLE);
  localparam logic [9:0] H_SYNC_BEG = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] H_SYNC_END = 10'(H_VISIBLE + H_FRONT + H_SYNC - 1);
  localparam logic [9:0] H_LAST     = 10'(H_VISIBLE + H_FRONT + H_SYNC + H_BACK - 1);
  localparam logic [9:0] V_VIS_END  = 10'(V_VISIBLE);
  localparam logic [9:0] V_SYNC_BEG = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] V_SYNC_END = 10'(V_VISIBLE + V_FRONT + V_SYNC - 1);
  localparam logic [9:0] V_LAST     = 10'(V_VISIBLE + V_FRONT + V_SYNC + V_BACK - 1);

  logic [9:0] x_q, x_d;
  logic [9:0] y_q, y_d;
  logic       hsync_q, hsync_d;
  logic       vsync_q, vsync_d;
  logic [3:0] red_q, red_d;
  logic [3:0] green_q, green_d;
  logic [3:0] blue_q, blue_d;
  logic       frame_q, frame_d;
  logic       visible;

  always_comb begin
    x_d = x_q + 10'd1;
    y_d = y_q;
    if (x_q == H_LAST) begin
      x_d = '0;
      y_d = (y_q == V_LAST) ? '0 : y_q + 10'd1;
    end

    // Everything below is decoded from the current counters, so after the
    // register stage the pins all describe the same (x,y).
    visible = (x_q < H_VIS_END) && (y_q < V_VIS_END);
    red_d   = visible ? rif.red   : 4'd0;
    green_d = visible ? rif.green : 4'd0;
    blue_d  = visible ? rif.blue  : 4'd0;
    hsync_d = !((x_q >= H_SYNC_BEG) && (x_q <= H_SYNC_END));
    vsync_d = !((y_q >= V_SYNC_BEG) && (y_q <= V_SYNC_END));
    frame_d = (y_q >= V_VIS_END);
  end

  always_ff @(posedge dclk) begin
    if (clr) begin
      x_q     <= '0;
      y_q     <= '0;
      hsync_q <= 1'b1;
      vsync_q <= 1'b1;
      red_q   <= '0;
      green_q <= '0;
      blue_q  <= '0;
      frame_q <= 1'b0;
    end else begin
      x_q     <= x_d;
      y_q     <= y_d;
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
      red_q   <= red_d;
      green_q <= green_d;
      blue_q  <= blue_d;
      frame_q <= frame_d;
    end
  end

  assign rif.x     = x_q;
  assign rif.y     = y_q;
  assign hsync     = hsync_q;
  assign vsync     = vsync_q;
  assign red_o     = red_q;
  assign green_o   = green_q;
  assign blue_o    = blue_q;
  assign frame_clk = frame_q;
  assign clk       = dclk;
endmodule

// File: tb/tb_vga_driver.sv
// Directed bench for vga_driver; vertical timing is shortened (6/2/2/3 lines, 13-line frame)
// so whole frames fit in a short run, horizontal timing is the full 800-pixel line.
module tb_vga_driver;
  logic       dclk = 1'b0;
  logic       clr;
  logic       hsync, vsync, clk, frame_clk;
  logic [3:0] red_o, green_o, blue_o;
  int         total = 0;
  int         bad = 0;
  int         n = 0;

  vga_driver_if rif();

  vga_driver #(
    .V_VISIBLE(6), .V_FRONT(2), .V_SYNC(2), .V_BACK(3)
  ) dut (
    .dclk(dclk), .clr(clr), .hsync(hsync), .vsync(vsync),
    .red_o(red_o), .green_o(green_o), .blue_o(blue_o),
    .clk(clk), .frame_clk(frame_clk), .rif(rif)
  );

  always #20 dclk = ~dclk;

  task automatic tick;
    @(posedge dclk);
    @(negedge dclk);
    n++;
  endtask

  task automatic test_reset;
    clr = 1'b1;
    rif.red = 4'd7; rif.green = 4'd8; rif.blue = 4'd3;
    tick; tick;
    total++; if (rif.x !== 10'd0) begin bad++; $display("FAIL reset_x got=%0d want=0", rif.x); end
    total++; if (rif.y !== 10'd0) begin bad++; $display("FAIL reset_y got=%0d want=0", rif.y); end
    total++; if (hsync !== 1'b1) begin bad++; $display("FAIL reset_hsync got=%b want=1", hsync); end
    total++; if (vsync !== 1'b1) begin bad++; $display("FAIL reset_vsync got=%b want=1", vsync); end
    total++; if ({red_o, green_o, blue_o} !== 12'h000) begin bad++; $display("FAIL reset_rgb got=%h want=000", {red_o, green_o, blue_o}); end
    total++; if (frame_clk !== 1'b0) begin bad++; $display("FAIL reset_frame_clk got=%b want=0", frame_clk); end
    total++; if (clk !== 1'b0) begin bad++; $display("FAIL clk_low got=%b want=0", clk); end
    #20;
    total++; if (clk !== 1'b1) begin bad++; $display("FAIL clk_high got=%b want=1", clk); end
    @(negedge dclk);
  endtask

  task automatic test_active_pixel;
    int errs = 0;
    int first_bad = -1;
    clr = 1'b0;
    n = 0;
    for (int k = 1; k <= 640; k++) begin
      tick;
      if ({red_o, green_o, blue_o} !== 12'h783 || hsync !== 1'b1 || rif.x !== 10'(k)) begin
        errs++;
        if (first_bad < 0) first_bad = k;
      end
    end
    total++;
    if (errs !== 0) begin
      bad++;
      $display("FAIL active_pixel bad_cycles=%0d first_bad_cycle=%0d want bad_cycles=0", errs, first_bad);
    end
    total++; if (rif.y !== 10'd0) begin bad++; $display("FAIL active_y got=%0d want=0", rif.y); end
  endtask

  task automatic test_hblank;
    int rgb_errs = 0;
    int low_cnt = 0;
    int first_low_x = -1;
    int last_low_x = -1;
    rif.red = 4'hF; rif.green = 4'hF; rif.blue = 4'hF;
    for (int k = 641; k <= 800; k++) begin
      tick;
      if ({red_o, green_o, blue_o} !== 12'h000) rgb_errs++;
      if (hsync === 1'b0) begin
        low_cnt++;
        if (first_low_x < 0) first_low_x = int'(rif.x);
        last_low_x = int'(rif.x);
      end
    end
    total++; if (rgb_errs !== 0) begin bad++; $display("FAIL hblank_rgb bad_cycles=%0d want=0", rgb_errs); end
    total++; if (low_cnt !== 96) begin bad++; $display("FAIL hsync_width got=%0d want=96", low_cnt); end
    total++; if (first_low_x !== 657) begin bad++; $display("FAIL hsync_start got_x=%0d want_x=657", first_low_x); end
    total++; if (last_low_x !== 752) begin bad++; $display("FAIL hsync_end got_x=%0d want_x=752", last_low_x); end
    total++; if (rif.x !== 10'd0 || rif.y !== 10'd1) begin bad++; $display("FAIL line_wrap got=(%0d,%0d) want=(0,1)", rif.x, rif.y); end
    tick;
    total++; if ({red_o, green_o, blue_o} !== 12'hFFF) begin bad++; $display("FAIL line1_rgb got=%h want=fff", {red_o, green_o, blue_o}); end
  endtask

  task automatic test_vertical;
    int vs_cnt = 0, fc_cnt = 0, rises = 0, blank_errs = 0;
    int vs_x = -1, vs_y = -1, fc_x = -1, fc_y = -1;
    int px = -1, py = -1, budget = 0;
    logic prev_fc;
    prev_fc = frame_clk;
    while (!(rif.x === 10'd0 && rif.y === 10'd0) && budget < 20000) begin
      px = int'(rif.x); py = int'(rif.y);
      tick;
      budget++;
      if (vsync === 1'b0) begin
        vs_cnt++;
        if (vs_x < 0) begin vs_x = int'(rif.x); vs_y = int'(rif.y); end
      end
      if (frame_clk === 1'b1) begin
        fc_cnt++;
        if (fc_x < 0) begin fc_x = int'(rif.x); fc_y = int'(rif.y); end
        if (prev_fc !== 1'b1) rises++;
      end
      prev_fc = frame_clk;
      if (rif.y >= 10'd6 && rif.x >= 10'd1 && rif.x <= 10'd640 && {red_o, green_o, blue_o} !== 12'h000)
        blank_errs++;
    end
    total++; if (budget >= 20000) begin bad++; $display("FAIL frame_wrap_timeout cycles=%0d want<20000", budget); end
    total++; if (vs_cnt !== 1600) begin bad++; $display("FAIL vsync_width got=%0d want=1600", vs_cnt); end
    total++; if (vs_x !== 1 || vs_y !== 8) begin bad++; $display("FAIL vsync_start got=(%0d,%0d) want=(1,8)", vs_x, vs_y); end
    total++; if (fc_cnt !== 5600) begin bad++; $display("FAIL frame_clk_width got=%0d want=5600", fc_cnt); end
    total++; if (fc_x !== 1 || fc_y !== 6) begin bad++; $display("FAIL frame_clk_start got=(%0d,%0d) want=(1,6)", fc_x, fc_y); end
    total++; if (rises !== 1) begin bad++; $display("FAIL frame_clk_rises got=%0d want=1", rises); end
    total++; if (blank_errs !== 0) begin bad++; $display("FAIL vblank_rgb bad_cycles=%0d want=0", blank_errs); end
    total++; if (px !== 799 || py !== 12) begin bad++; $display("FAIL frame_wrap_prev got=(%0d,%0d) want=(799,12)", px, py); end
    total++; if (n !== 10400) begin bad++; $display("FAIL frame_period got=%0d want=10400", n); end
    tick;
    total++; if (frame_clk !== 1'b0 || vsync !== 1'b1) begin bad++; $display("FAIL new_frame_flags got fc=%b vs=%b want fc=0 vs=1", frame_clk, vsync); end
  endtask

  task automatic test_mid_reset;
    int budget = 0;
    while (!(rif.x === 10'd300 && rif.y === 10'd3) && budget < 20000) begin tick; budget++; end
    total++; if (budget >= 20000) begin bad++; $display("FAIL mid_seek1_timeout cycles=%0d want<20000", budget); end
    clr = 1'b1;
    tick;
    total++; if (rif.x !== 10'd0 || rif.y !== 10'd0) begin bad++; $display("FAIL mid_reset_xy got=(%0d,%0d) want=(0,0)", rif.x, rif.y); end
    total++; if ({red_o, green_o, blue_o} !== 12'h000) begin bad++; $display("FAIL mid_reset_rgb got=%h want=000", {red_o, green_o, blue_o}); end
    total++; if (hsync !== 1'b1 || vsync !== 1'b1) begin bad++; $display("FAIL mid_reset_sync got hs=%b vs=%b want 1 1", hsync, vsync); end
    clr = 1'b0;
    tick;
    total++; if (rif.x !== 10'd1 || rif.y !== 10'd0) begin bad++; $display("FAIL restart_xy got=(%0d,%0d) want=(1,0)", rif.x, rif.y); end
    total++; if ({red_o, green_o, blue_o} !== 12'hFFF) begin bad++; $display("FAIL restart_rgb got=%h want=fff", {red_o, green_o, blue_o}); end

    budget = 0;
    while (!(rif.x === 10'd700 && rif.y === 10'd8) && budget < 20000) begin tick; budget++; end
    total++; if (budget >= 20000) begin bad++; $display("FAIL mid_seek2_timeout cycles=%0d want<20000", budget); end
    total++; if (hsync !== 1'b0 || vsync !== 1'b0 || frame_clk !== 1'b1) begin bad++; $display("FAIL pre_reset_sync got hs=%b vs=%b fc=%b want 0 0 1", hsync, vsync, frame_clk); end
    clr = 1'b1;
    tick;
    total++; if (hsync !== 1'b1 || vsync !== 1'b1 || frame_clk !== 1'b0) begin bad++; $display("FAIL sync_reset got hs=%b vs=%b fc=%b want 1 1 0", hsync, vsync, frame_clk); end
    total++; if (rif.x !== 10'd0 || rif.y !== 10'd0) begin bad++; $display("FAIL sync_reset_xy got=(%0d,%0d) want=(0,0)", rif.x, rif.y); end
    clr = 1'b0;
  endtask

  initial begin
    clr = 1'b1;
    rif.red = '0; rif.green = '0; rif.blue = '0;
    @(negedge dclk);
    test_reset;
    $display("reset checks done total=%0d bad=%0d", total, bad);
    test_active_pixel;
    $display("active pixel checks done total=%0d bad=%0d", total, bad);
    test_hblank;
    $display("horizontal blank checks done total=%0d bad=%0d", total, bad);
    test_vertical;
    $display("vertical/frame checks done total=%0d bad=%0d", total, bad);
    test_mid_reset;
    $display("mid-frame reset checks done total=%0d bad=%0d", total, bad);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
